// File: rtl/tlb_mp.sv
// tlb_mp: fully-associative TLB with NPORT independent search ports.
//
// Each search port registers its lookup result one cycle after s_req; results
// hold while s_req is low. The array is written by TLBWR (w_index) or TLBFILL
// (internal fill index), invalidated by INVTLB ops 0..6, and read
// combinationally through the r_* port.
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   s_req/s_vppn/s_va_bit12/s_asid search request, packed per port
//   s_rvalid/s_found/s_index/...  registered search results, packed per port
//   invtlb_*                      INVTLB strobe, op, ASID, VPPN; badop pulse
//   we/w_fill/w_index/w_*         entry write
//   fill_index                    index the next TLBFILL will write
//   r_index/r_*                   combinational entry read
module tlb_mp #(
   parameter int TLBNUM = 16,
   parameter int NPORT  = 2,
   localparam int IW    = $clog2(TLBNUM)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NPORT-1:0]      s_req,
   input  logic [19*NPORT-1:0]   s_vppn,
   input  logic [NPORT-1:0]      s_va_bit12,
   input  logic [10*NPORT-1:0]   s_asid,
   output logic [NPORT-1:0]      s_rvalid,
   output logic [NPORT-1:0]      s_found,
   output logic [IW*NPORT-1:0]   s_index,
   output logic [20*NPORT-1:0]   s_ppn,
   output logic [6*NPORT-1:0]    s_ps,
   output logic [2*NPORT-1:0]    s_plv,
   output logic [2*NPORT-1:0]    s_mat,
   output logic [NPORT-1:0]      s_d,
   output logic [NPORT-1:0]      s_v,
   input  logic                  invtlb_valid,
   input  logic [4:0]            invtlb_op,
   input  logic [9:0]            invtlb_asid,
   input  logic [18:0]           invtlb_vppn,
   output logic                  invtlb_badop,
   input  logic                  we,
   input  logic                  w_fill,
   input  logic [IW-1:0]         w_index,
   input  logic                  w_e,
   input  logic [18:0]           w_vppn,
   input  logic [5:0]            w_ps,
   input  logic [9:0]            w_asid,
   input  logic                  w_g,
   input  logic [19:0]           w_ppn0,
   input  logic [19:0]           w_ppn1,
   input  logic [1:0]            w_plv0,
   input  logic [1:0]            w_plv1,
   input  logic [1:0]            w_mat0,
   input  logic [1:0]            w_mat1,
   input  logic                  w_d0,
   input  logic                  w_d1,
   input  logic                  w_v0,
   input  logic                  w_v1,
   output logic [IW-1:0]         fill_index,
   input  logic [IW-1:0]         r_index,
   output logic                  r_e,
   output logic [18:0]           r_vppn,
   output logic [5:0]            r_ps,
   output logic [9:0]            r_asid,
   output logic                  r_g,
   output logic [19:0]           r_ppn0,
   output logic [19:0]           r_ppn1,
   output logic [1:0]            r_plv0,
   output logic [1:0]            r_plv1,
   output logic [1:0]            r_mat0,
   output logic [1:0]            r_mat1,
   output logic                  r_d0,
   output logic                  r_d1,
   output logic                  r_v0,
   output logic                  r_v1
);

   logic [TLBNUM-1:0] tlb_e;
   logic [TLBNUM-1:0] tlb_g;
   logic [18:0]       tlb_vppn [TLBNUM];
   logic [5:0]        tlb_ps   [TLBNUM];
   logic [9:0]        tlb_asid [TLBNUM];
   logic [19:0]       tlb_ppn0 [TLBNUM];
   logic [19:0]       tlb_ppn1 [TLBNUM];
   logic [1:0]        tlb_plv0 [TLBNUM];
   logic [1:0]        tlb_plv1 [TLBNUM];
   logic [1:0]        tlb_mat0 [TLBNUM];
   logic [1:0]        tlb_mat1 [TLBNUM];
   logic [TLBNUM-1:0] tlb_d0, tlb_d1, tlb_v0, tlb_v1;

   // 4 MB pages (ps 21) compare only VPPN[18:10]; everything else is 4 KB.
   function automatic logic vppn_hit(input logic [18:0] ev, input logic [5:0] eps,
                                     input logic [18:0] qv);
      return (eps == 6'd21) ? (ev[18:10] == qv[18:10]) : (ev == qv);
   endfunction

   // ---------------- search ----------------
   logic            hit_n [NPORT];
   logic [IW-1:0]   idx_n [NPORT];
   logic            odd_n [NPORT];

   always_comb begin
      for (int p = 0; p < NPORT; p++) begin
         hit_n[p] = 1'b0;
         idx_n[p] = '0;
         // descending scan so the lowest matching index is the one kept
         for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (tlb_e[i] && (tlb_g[i] || tlb_asid[i] == s_asid[p*10 +: 10]) &&
                vppn_hit(tlb_vppn[i], tlb_ps[i], s_vppn[p*19 +: 19])) begin
               hit_n[p] = 1'b1;
               idx_n[p] = IW'(i);
            end
         end
         odd_n[p] = (tlb_ps[idx_n[p]] == 6'd21) ? s_vppn[p*19 + 9] : s_va_bit12[p];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s_rvalid <= '0;
         s_found  <= '0;
         s_index  <= '0;
         s_ppn    <= '0;
         s_ps     <= '0;
         s_plv    <= '0;
         s_mat    <= '0;
         s_d      <= '0;
         s_v      <= '0;
      end else begin
         s_rvalid <= s_req;
         for (int p = 0; p < NPORT; p++) begin
            if (s_req[p]) begin
               s_found[p]          <= hit_n[p];
               s_index[p*IW +: IW] <= hit_n[p] ? idx_n[p] : '0;
               s_ps[p*6 +: 6]      <= hit_n[p] ? tlb_ps[idx_n[p]] : '0;
               if (hit_n[p] && odd_n[p]) begin
                  s_ppn[p*20 +: 20] <= tlb_ppn1[idx_n[p]];
                  s_plv[p*2 +: 2]   <= tlb_plv1[idx_n[p]];
                  s_mat[p*2 +: 2]   <= tlb_mat1[idx_n[p]];
                  s_d[p]            <= tlb_d1[idx_n[p]];
                  s_v[p]            <= tlb_v1[idx_n[p]];
               end else if (hit_n[p]) begin
                  s_ppn[p*20 +: 20] <= tlb_ppn0[idx_n[p]];
                  s_plv[p*2 +: 2]   <= tlb_plv0[idx_n[p]];
                  s_mat[p*2 +: 2]   <= tlb_mat0[idx_n[p]];
                  s_d[p]            <= tlb_d0[idx_n[p]];
                  s_v[p]            <= tlb_v0[idx_n[p]];
               end else begin
                  s_ppn[p*20 +: 20] <= '0;
                  s_plv[p*2 +: 2]   <= '0;
                  s_mat[p*2 +: 2]   <= '0;
                  s_d[p]            <= 1'b0;
                  s_v[p]            <= 1'b0;
               end
            end
         end
      end
   end

   // ---------------- fill index ----------------
   logic          any_free;
   logic [IW-1:0] free_idx;
   logic [IW-1:0] fill_ptr;
   logic [IW-1:0] w_target;

   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (!tlb_e[i]) begin
            any_free = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   assign fill_index = any_free ? free_idx : fill_ptr;
   assign w_target   = w_fill ? fill_index : w_index;

   // TLBNUM is a power of two, so the natural wrap is mod TLBNUM
   always_ff @(posedge clk) begin
      if (reset)
         fill_ptr <= '0;
      else if (we && w_fill && !any_free)
         fill_ptr <= fill_ptr + 1'b1;
   end

   // ---------------- INVTLB ----------------
   logic [TLBNUM-1:0] inv_sel;

   always_comb begin
      inv_sel = '0;
      for (int i = 0; i < TLBNUM; i++) begin
         case (invtlb_op)
            5'd0, 5'd1: inv_sel[i] = 1'b1;
            5'd2: inv_sel[i] = tlb_e[i] & tlb_g[i];
            5'd3: inv_sel[i] = tlb_e[i] & ~tlb_g[i];
            5'd4: inv_sel[i] = tlb_e[i] & ~tlb_g[i] & (tlb_asid[i] == invtlb_asid);
            5'd5: inv_sel[i] = tlb_e[i] & ~tlb_g[i] & (tlb_asid[i] == invtlb_asid) &
                               vppn_hit(tlb_vppn[i], tlb_ps[i], invtlb_vppn);
            5'd6: inv_sel[i] = tlb_e[i] & (tlb_g[i] | (tlb_asid[i] == invtlb_asid)) &
                               vppn_hit(tlb_vppn[i], tlb_ps[i], invtlb_vppn);
            default: inv_sel[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         invtlb_badop <= 1'b0;
      else
         invtlb_badop <= invtlb_valid && (invtlb_op > 5'd6);
   end

   // ---------------- array update ----------------
   // Write follows invalidate so a same-cycle write owns its entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         tlb_e <= '0;
      end else begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (invtlb_valid && inv_sel[i])
               tlb_e[i] <= 1'b0;
            if (we && w_target == IW'(i))
               tlb_e[i] <= w_e;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         tlb_g[w_target]    <= w_g;
         tlb_vppn[w_target] <= w_vppn;
         tlb_ps[w_target]   <= w_ps;
         tlb_asid[w_target] <= w_asid;
         tlb_ppn0[w_target] <= w_ppn0;
         tlb_ppn1[w_target] <= w_ppn1;
         tlb_plv0[w_target] <= w_plv0;
         tlb_plv1[w_target] <= w_plv1;
         tlb_mat0[w_target] <= w_mat0;
         tlb_mat1[w_target] <= w_mat1;
         tlb_d0[w_target]   <= w_d0;
         tlb_d1[w_target]   <= w_d1;
         tlb_v0[w_target]   <= w_v0;
         tlb_v1[w_target]   <= w_v1;
      end
   end

   // ---------------- read ----------------
   assign r_e    = tlb_e[r_index];
   assign r_g    = tlb_g[r_index];
   assign r_vppn = tlb_vppn[r_index];
   assign r_ps   = tlb_ps[r_index];
   assign r_asid = tlb_asid[r_index];
   assign r_ppn0 = tlb_ppn0[r_index];
   assign r_ppn1 = tlb_ppn1[r_index];
   assign r_plv0 = tlb_plv0[r_index];
   assign r_plv1 = tlb_plv1[r_index];
   assign r_mat0 = tlb_mat0[r_index];
   assign r_mat1 = tlb_mat1[r_index];
   assign r_d0   = tlb_d0[r_index];
   assign r_d1   = tlb_d1[r_index];
   assign r_v0   = tlb_v0[r_index];
   assign r_v1   = tlb_v1[r_index];

endmodule

// File: tb/tb_tlb_mp.sv
// tb_tlb_mp: directed-vector bench for tlb_mp (TLBNUM 16, NPORT 2).
module tb_tlb_mp;
   localparam int TLBNUM = 16;
   localparam int NPORT  = 2;
   localparam int IW     = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [NPORT-1:0]    s_req = '0;
   logic [19*NPORT-1:0] s_vppn = '0;
   logic [NPORT-1:0]    s_va_bit12 = '0;
   logic [10*NPORT-1:0] s_asid = '0;
   logic [NPORT-1:0]    s_rvalid, s_found, s_d, s_v;
   logic [IW*NPORT-1:0] s_index;
   logic [20*NPORT-1:0] s_ppn;
   logic [6*NPORT-1:0]  s_ps;
   logic [2*NPORT-1:0]  s_plv, s_mat;
   logic        invtlb_valid = 1'b0;
   logic [4:0]  invtlb_op = '0;
   logic [9:0]  invtlb_asid = '0;
   logic [18:0] invtlb_vppn = '0;
   logic        invtlb_badop;
   logic        we = 1'b0, w_fill = 1'b0;
   logic [IW-1:0] w_index = '0;
   logic        w_e = 1'b0, w_g = 1'b0;
   logic [18:0] w_vppn = '0;
   logic [5:0]  w_ps = '0;
   logic [9:0]  w_asid = '0;
   logic [19:0] w_ppn0 = '0, w_ppn1 = '0;
   logic [1:0]  w_plv0 = '0, w_plv1 = '0, w_mat0 = '0, w_mat1 = '0;
   logic        w_d0 = 1'b0, w_d1 = 1'b0, w_v0 = 1'b0, w_v1 = 1'b0;
   logic [IW-1:0] fill_index;
   logic [IW-1:0] r_index = '0;
   logic        r_e, r_g, r_d0, r_d1, r_v0, r_v1;
   logic [18:0] r_vppn;
   logic [5:0]  r_ps;
   logic [9:0]  r_asid;
   logic [19:0] r_ppn0, r_ppn1;
   logic [1:0]  r_plv0, r_plv1, r_mat0, r_mat1;

   int n_chk = 0;
   int n_err = 0;

   tlb_mp #(.TLBNUM(TLBNUM), .NPORT(NPORT)) dut (
      .clk(clk), .reset(reset),
      .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12), .s_asid(s_asid),
      .s_rvalid(s_rvalid), .s_found(s_found), .s_index(s_index), .s_ppn(s_ppn),
      .s_ps(s_ps), .s_plv(s_plv), .s_mat(s_mat), .s_d(s_d), .s_v(s_v),
      .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .invtlb_asid(invtlb_asid),
      .invtlb_vppn(invtlb_vppn), .invtlb_badop(invtlb_badop),
      .we(we), .w_fill(w_fill), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn),
      .w_ps(w_ps), .w_asid(w_asid), .w_g(w_g), .w_ppn0(w_ppn0), .w_ppn1(w_ppn1),
      .w_plv0(w_plv0), .w_plv1(w_plv1), .w_mat0(w_mat0), .w_mat1(w_mat1),
      .w_d0(w_d0), .w_d1(w_d1), .w_v0(w_v0), .w_v1(w_v1),
      .fill_index(fill_index), .r_index(r_index),
      .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid), .r_g(r_g),
      .r_ppn0(r_ppn0), .r_ppn1(r_ppn1), .r_plv0(r_plv0), .r_plv1(r_plv1),
      .r_mat0(r_mat0), .r_mat1(r_mat1), .r_d0(r_d0), .r_d1(r_d1), .r_v0(r_v0), .r_v1(r_v1)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_w(input logic fill, input int idx, input logic e, input logic [18:0] vppn,
                        input logic [5:0] ps, input logic [9:0] asid, input logic g,
                        input logic [19:0] p0, input logic [19:0] p1);
      w_fill = fill; w_index = IW'(idx); w_e = e; w_vppn = vppn; w_ps = ps;
      w_asid = asid; w_g = g; w_ppn0 = p0; w_ppn1 = p1;
      w_plv0 = 2'd0; w_plv1 = 2'd3; w_mat0 = 2'd1; w_mat1 = 2'd2;
      w_d0 = 1'b0; w_d1 = 1'b1; w_v0 = 1'b1; w_v1 = 1'b1;
   endtask

   task automatic tlbwr(input logic fill, input int idx, input logic e, input logic [18:0] vppn,
                        input logic [5:0] ps, input logic [9:0] asid, input logic g,
                        input logic [19:0] p0, input logic [19:0] p1);
      @(negedge clk);
      set_w(fill, idx, e, vppn, ps, asid, g, p0, p1);
      we = 1'b1;
      @(negedge clk);
      we = 1'b0; w_fill = 1'b0;
   endtask

   task automatic search(input int p, input logic [18:0] vppn, input logic b12, input logic [9:0] asid);
      @(negedge clk);
      s_req = '0; s_req[p] = 1'b1;
      s_vppn[p*19 +: 19] = vppn; s_va_bit12[p] = b12; s_asid[p*10 +: 10] = asid;
      @(negedge clk);
      s_req = '0;
   endtask

   task automatic check_hit(input string tag, input int p, input logic found, input int idx,
                            input logic [19:0] ppn);
      check_eq({tag, "_rvalid"}, 32'(s_rvalid[p]), 32'd1);
      check_eq({tag, "_found"}, 32'(s_found[p]), 32'(found));
      check_eq({tag, "_index"}, 32'(s_index[p*IW +: IW]), 32'(idx));
      check_eq({tag, "_ppn"}, 32'(s_ppn[p*20 +: 20]), 32'(ppn));
   endtask

   task automatic invtlb(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
      @(negedge clk);
      invtlb_valid = 1'b1; invtlb_op = op; invtlb_asid = asid; invtlb_vppn = vppn;
      @(negedge clk);
      invtlb_valid = 1'b0;
   endtask

   task automatic read_e5(output logic [4:0] v);
      for (int i = 0; i < 5; i++) begin
         r_index = IW'(i);
         #1;
         v[i] = r_e;
      end
   endtask

   task automatic populate();
      tlbwr(1'b0, 0, 1'b1, 19'h100, 6'd12, 10'd1, 1'b1, 20'h0, 20'h0);
      tlbwr(1'b0, 1, 1'b1, 19'h100, 6'd12, 10'd1, 1'b0, 20'h0, 20'h0);
      tlbwr(1'b0, 2, 1'b1, 19'h100, 6'd12, 10'd2, 1'b0, 20'h0, 20'h0);
      tlbwr(1'b0, 3, 1'b1, 19'h200, 6'd12, 10'd2, 1'b1, 20'h0, 20'h0);
      tlbwr(1'b0, 4, 1'b1, 19'h200, 6'd12, 10'd1, 1'b0, 20'h0, 20'h0);
   endtask

   logic [4:0] ev;

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_eq("rst_rvalid", 32'(s_rvalid), 32'd0);
      check_eq("rst_found", 32'(s_found), 32'd0);
      check_eq("rst_fill_index", 32'(fill_index), 32'd0);
      check_eq("rst_badop", 32'(invtlb_badop), 32'd0);

      // empty-array search on both ports
      @(negedge clk);
      s_req = 2'b11; s_vppn = {19'h00001, 19'h00001}; s_asid = '0;
      @(negedge clk);
      s_req = '0;
      check_eq("empty_rvalid", 32'(s_rvalid), 32'd3);
      check_eq("empty_found", 32'(s_found), 32'd0);
      check_eq("empty_ppn", 32'(s_ppn[19:0]) | 32'(s_ppn[39:20]), 32'd0);
      check_eq("empty_fill", 32'(fill_index), 32'd0);

      // 4 KB entry at index 3
      tlbwr(1'b0, 3, 1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'hAAAAA, 20'hBBBBB);
      check_eq("wr_fill_index", 32'(fill_index), 32'd0);
      r_index = 4'd3; #1;
      check_eq("rd_vppn", 32'(r_vppn), 32'h12345);
      check_eq("rd_ppn1", 32'(r_ppn1), 32'hBBBBB);
      search(1, 19'h12345, 1'b1, 10'd5);
      check_hit("k4_odd", 1, 1'b1, 3, 20'hBBBBB);
      check_eq("k4_odd_plv", 32'(s_plv[3:2]), 32'd3);
      check_eq("k4_hold_p0", 32'(s_found[0]), 32'd0);
      search(0, 19'h12345, 1'b0, 10'd5);
      check_hit("k4_even", 0, 1'b1, 3, 20'hAAAAA);
      search(1, 19'h12345, 1'b1, 10'd6);
      check_hit("k4_asid_miss", 1, 1'b0, 0, 20'h0);

      // 4 MB global entry at index 5
      tlbwr(1'b0, 5, 1'b1, 19'h12200, 6'd21, 10'd5, 1'b1, 20'h11111, 20'h22222);
      search(0, 19'h123FF, 1'b0, 10'd9);
      check_hit("m4_odd", 0, 1'b1, 5, 20'h22222);
      check_eq("m4_ps", 32'(s_ps[5:0]), 32'd21);
      search(1, 19'h12600, 1'b0, 10'd5);
      check_hit("m4_miss", 1, 1'b0, 0, 20'h0);
      search(1, 19'h12345, 1'b0, 10'd5);
      check_hit("multi_lowest", 1, 1'b1, 3, 20'hAAAAA);

      // fill sequencing
      @(negedge clk); reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      check_eq("rst2_rvalid", 32'(s_rvalid), 32'd0);
      for (int k = 0; k < TLBNUM; k++) begin
         check_eq($sformatf("fill_%0d", k), 32'(fill_index), 32'(k));
         tlbwr(1'b1, 0, 1'b1, 19'(k), 6'd12, 10'(k), 1'b0, 20'(k), 20'(k));
      end
      check_eq("full_fill_index", 32'(fill_index), 32'd0);
      tlbwr(1'b1, 9, 1'b1, 19'h7777, 6'd12, 10'd0, 1'b0, 20'h77777, 20'h0);
      check_eq("ptr_after_victim", 32'(fill_index), 32'd1);
      r_index = 4'd0; #1;
      check_eq("victim_ppn0", 32'(r_ppn0), 32'h77777);
      invtlb(5'd4, 10'd2, 19'h0);
      check_eq("op4_fill_index", 32'(fill_index), 32'd2);
      r_index = 4'd3; #1;
      check_eq("op4_keep3", 32'(r_e), 32'd1);

      // INVTLB selection over a mixed population
      populate(); invtlb(5'd2, 10'd0, 19'h0); read_e5(ev);
      check_eq("op2", 32'(ev), 32'b10110);
      populate(); invtlb(5'd3, 10'd0, 19'h0); read_e5(ev);
      check_eq("op3", 32'(ev), 32'b01001);
      populate(); invtlb(5'd5, 10'd1, 19'h100); read_e5(ev);
      check_eq("op5", 32'(ev), 32'b11101);
      populate(); invtlb(5'd6, 10'd2, 19'h100); read_e5(ev);
      check_eq("op6", 32'(ev), 32'b11010);
      populate();
      check_eq("badop_idle", 32'(invtlb_badop), 32'd0);
      invtlb(5'd9, 10'd1, 19'h100);
      check_eq("badop_pulse", 32'(invtlb_badop), 32'd1);
      read_e5(ev);
      check_eq("op9_nochange", 32'(ev), 32'b11111);
      @(negedge clk);
      check_eq("badop_clear", 32'(invtlb_badop), 32'd0);
      invtlb(5'd0, 10'd0, 19'h0); read_e5(ev);
      check_eq("op0", 32'(ev), 32'b00000);

      // same-cycle search and write
      @(negedge clk);
      set_w(1'b0, 7, 1'b1, 19'h3ABCD, 6'd12, 10'd3, 1'b0, 20'h55555, 20'h66666);
      we = 1'b1;
      s_req = 2'b01; s_vppn[18:0] = 19'h3ABCD; s_asid[9:0] = 10'd3; s_va_bit12[0] = 1'b0;
      @(negedge clk);
      we = 1'b0; s_req = '0;
      check_hit("race_miss", 0, 1'b0, 0, 20'h0);
      search(0, 19'h3ABCD, 1'b0, 10'd3);
      check_hit("race_next_hit", 0, 1'b1, 7, 20'h55555);

      // same-cycle INVTLB op 0 and write: the write survives
      @(negedge clk);
      set_w(1'b0, 8, 1'b1, 19'h1, 6'd12, 10'd1, 1'b0, 20'h1, 20'h1);
      we = 1'b1; invtlb_valid = 1'b1; invtlb_op = 5'd0;
      @(negedge clk);
      we = 1'b0; invtlb_valid = 1'b0;
      r_index = 4'd8; #1;
      check_eq("wi_keep8", 32'(r_e), 32'd1);
      r_index = 4'd7; #1;
      check_eq("wi_clear7", 32'(r_e), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
